// File: rtl/bsram_reader.sv
// Purpose: streams length bytes from a 2-cycle-latency SDPB block RAM port B, starting at start_addr.
// Latency: start sampled in cycle s -> first read in s+1, first m_valid in s+4; then one byte/cycle.
// Backpressure: reads are throttled so FIFO occupancy plus reads in flight never exceeds FIFO_DEPTH.
module bsram_reader #(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_adb,
    output logic              ram_ceb,
    output logic              ram_oce,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   adb_q;
    logic [ADDR_W:0]     remain_q;
    logic [1:0]          infl_q;
    logic                zero_done_q;
    logic [DATA_W-1:0]   fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [CNT_W-1:0]    count_q;

    logic [CNT_W-1:0]    inflight;
    logic [CNT_W:0]      occupancy;
    logic                issue;
    logic                push;
    logic                pop;
    logic                last_pop;

    assign inflight  = CNT_W'(infl_q[0]) + CNT_W'(infl_q[1]);
    assign occupancy = {1'b0, count_q} + {1'b0, inflight};
    // Count reads still in the RAM pipe as occupied slots so captured data always has room.
    assign issue     = (state_q == S_ISSUE) && (occupancy < (CNT_W+1)'(FIFO_DEPTH));

    assign push      = infl_q[1];
    assign m_valid   = (count_q != '0);
    assign m_data    = fifo_q[rd_ptr_q];
    assign pop       = m_valid && m_ready;
    assign last_pop  = (state_q == S_DRAIN) && (inflight == '0) &&
                       (count_q == CNT_W'(1)) && pop;

    assign busy      = (state_q != S_IDLE);
    assign done      = last_pop || zero_done_q;
    assign ram_ceb   = issue;
    assign ram_adb   = issue ? addr_q : adb_q;
    assign ram_oce   = busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            adb_q       <= '0;
            remain_q    <= '0;
            infl_q      <= '0;
            zero_done_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            zero_done_q <= 1'b0;
            infl_q      <= {infl_q[0], issue};

            if (issue) begin
                adb_q    <= addr_q;
                addr_q   <= addr_q + 1'b1;
                remain_q <= remain_q - 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (length != '0) begin
                            addr_q   <= start_addr;
                            remain_q <= length;
                            state_q  <= S_ISSUE;
                        end else begin
                            zero_done_q <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (issue && (remain_q == (ADDR_W+1)'(1))) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (last_pop) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            if (push) begin
                fifo_q[wr_ptr_q] <= ram_dout;
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: doc/bsram_reader.md
Name: bsram_reader

Overview:
- Read-side engine for the 8-bit Gowin_SDPB block RAM.
- It is the counterpart of the boot-time writer that fills memory through port A.
- On a start command it issues sequential reads on port B (adb/ceb/oce) for a given start address and length.
- It absorbs the RAM's fixed 2-cycle read latency and streams the bytes out on a valid/ready interface with full backpressure, through a small internal FIFO.

Parameters:
- ADDR_W, 13, RAM address width; addresses wrap modulo 2^ADDR_W.
- DATA_W, 8, RAM data width.
- FIFO_DEPTH, 4, output FIFO entries; power of two, at least 2 (minimum 4 for a full-rate stream).

Ports:
- clk  input  1  system clock; also drives RAM clkb.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  one-cycle command strobe; sampled only in IDLE.
- start_addr  input  ADDR_W  first RAM address to read.
- length  input  ADDR_W+1  byte count, 0..2^ADDR_W.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse when the last byte is accepted downstream.
- ram_adb  output  ADDR_W  port B read address.
- ram_ceb  output  1  port B read enable.
- ram_oce  output  1  port B output-register enable.
- ram_dout  input  DATA_W  port B read data.
- m_data  output  DATA_W  stream data.
- m_valid  output  1  stream valid.
- m_ready  input  1  stream ready from the consumer.

Behaviour:
- Reset: the following are all 0 and the FIFO is empty: busy, done, ram_ceb, ram_oce, ram_adb, m_valid, m_data, in-flight tracker, counters. State is IDLE.
- RAM timing contract: a read issued in cycle t (ram_ceb=1, ram_adb=A, ram_oce=1) presents mem[A] on ram_dout in cycle t+2.
  - A 2-stage in-flight shift register marks the cycles whose ram_dout must be captured.
  - Captured data is written into the FIFO at the end of cycle t+2.
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - start=1 with length!=0: latch addr=start_addr and remaining=length, go to ISSUE, busy=1.
  - start=1 with length==0: no RAM access; pulse done in the next cycle; busy stays 0.
- ISSUE:
  - A read is issued in a cycle only when fifo_count + inflight < FIFO_DEPTH, where inflight counts reads still in the latency pipe.
  - Each issue increments addr (wrapping, 0x1FFF -> 0x0000 for ADDR_W=13) and decrements remaining.
  - When the last read is issued, go to DRAIN.
  - ram_ceb=0 in any cycle without an issue; ram_adb holds its last value.
- DRAIN:
  - No issues.
  - Exit when inflight==0, the FIFO is empty, and the final m_valid&&m_ready handshake occurs.
  - In that handshake cycle, pulse done=1 for one cycle and clear busy; next state is IDLE.
- ram_oce=1 whenever busy=1, so data in flight always lands.
- Stream rules:
  - m_valid = FIFO not empty; m_data = FIFO head (first-word-fall-through register).
  - A transfer happens when m_valid && m_ready.
  - m_data and m_valid are stable while m_valid=1 and m_ready=0.
  - A FIFO push and pop in the same cycle leave the count unchanged.
  - The FIFO never overflows; issue throttling guarantees this.
- Throughput: with m_ready held at 1, one byte per cycle after initial latency. m_valid first rises in cycle s+4, where s is the cycle start is sampled (issue at s+1, data at s+3, FIFO output at s+4).
- start while busy=1 is ignored; no effect on the current transfer.
- Reset mid-operation:
  - Abort immediately to the reset state.
  - Data in flight is discarded and no done pulse is produced.
  - After release, a new start works normally.
- Byte count: exactly length bytes are emitted, in address order.

Test Plan:
- Preload 0x0200..0x0203 = 06,07,08,09 via port A; start_addr=0x0200, length=4, m_ready=1 -> m_data 06,07,08,09 on four consecutive cycles; first m_valid at s+4; done pulses with the 09 handshake; busy then 0.
- Same read with m_ready toggling 1,0,0,1,... -> identical byte order, no drop or duplicate; m_data stable while stalled; ram_ceb never issues past FIFO capacity (fifo_count+inflight<=4 at all times).
- Preload 0x1FFE,0x1FFF,0x0000,0x0001 = A1,A2,A3,A4; start_addr=0x1FFE, length=4 -> ram_adb sequence 1FFE,1FFF,0000,0001; stream A1,A2,A3,A4.
- length=0 -> done pulses the cycle after start; ram_ceb stays 0; m_valid never rises.
- During a length=8 read, assert start with start_addr=0x0000 -> ignored; the original 8 bytes stream unchanged; only one done pulse.
- Assert rst_n=0 mid-stream (after 2 of 8 bytes) -> busy, m_valid, ram_ceb drop asynchronously to 0; no done. After release, start 0x0200 length 1 returns 06.
